// File: rtl/axi_lite_write_arbiter_if.sv
// Bus bundle for the AXI-lite write arbiter: requester side, master command port,
// B-channel snoop, completion reporting and the FSM state debug view.
interface axi_lite_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 8,
  parameter int ID_WD   = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ADDR_WD-1:0] req_addr;
  logic [NUM_REQ*DATA_WD-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;

  logic                       m_tvalid;
  logic [ADDR_WD-1:0]         m_taddr;
  logic [DATA_WD-1:0]         m_tdata;
  logic                       m_tready;

  logic                       mon_bvalid;
  logic                       mon_bready;
  logic [1:0]                 mon_bresp;

  logic                       done_valid;
  logic [ID_WD-1:0]           done_id;
  logic [1:0]                 done_resp;
  logic                       busy;
  logic [7:0]                 err_cnt;
  logic [1:0]                 state;

  // Arbiter side
  modport master (
    input  req_valid, req_addr, req_data, m_tready, mon_bvalid, mon_bready, mon_bresp,
    output req_ready, m_tvalid, m_taddr, m_tdata, done_valid, done_id, done_resp,
           busy, err_cnt, state
  );

  // Requesters / write master / observer side
  modport slave (
    output req_valid, req_addr, req_data, m_tready, mon_bvalid, mon_bready, mon_bresp,
    input  req_ready, m_tvalid, m_taddr, m_tdata, done_valid, done_id, done_resp,
           busy, err_cnt, state
  );
endinterface

// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter sharing one AXI-lite write master command port between NUM_REQ
// requesters, one write in flight, with completion routed back from the B snoop.
module axi_lite_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 8,
  parameter int ID_WD   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_lite_write_arbiter_if.master  bus
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // req_valid/req_ready: requester -> arbiter (ready only in IDLE, one-hot to the winner).
  // m_tvalid/m_tready: arbiter -> master; m_t* stay stable while m_tvalid && !m_tready.
  // mon_bvalid/mon_bready: passive snoop, only acted on in WAIT_B.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT_B = 2'd2;

  logic [1:0]         r_state;
  logic [ID_WD-1:0]   r_last_grant;
  logic [ID_WD-1:0]   r_grant_id;
  logic               r_m_tvalid;
  logic [ADDR_WD-1:0] r_m_taddr;
  logic [DATA_WD-1:0] r_m_tdata;
  logic               r_done_valid;
  logic [ID_WD-1:0]   r_done_id;
  logic [1:0]         r_done_resp;
  logic [7:0]         r_err_cnt;

  logic               w_any;
  logic [ID_WD-1:0]   w_winner;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [ADDR_WD-1:0] w_sel_addr;
  logic [DATA_WD-1:0] w_sel_data;
  logic               w_cmd_fire;
  logic               w_b_fire;

  // Scan starts just after the last winner and wraps, so the last winner is checked last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && bus.req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
        w_any    = 1'b1;
        w_winner = ID_WD'((int'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_any;
  assign w_req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_sel_addr  = bus.req_addr[int'(w_winner)*ADDR_WD +: ADDR_WD];
  assign w_sel_data  = bus.req_data[int'(w_winner)*DATA_WD +: DATA_WD];
  assign w_cmd_fire  = r_m_tvalid && bus.m_tready;
  assign w_b_fire    = bus.mon_bvalid && bus.mon_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_WD'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_taddr    <= '0;
      r_m_tdata    <= '0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_done_resp  <= 2'b00;
      r_err_cnt    <= 8'd0;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m_taddr    <= w_sel_addr;
            r_m_tdata    <= w_sel_data;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_m_tvalid   <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_cmd_fire) begin
            r_m_tvalid <= 1'b0;
            r_state    <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (w_b_fire) begin
            r_done_valid <= 1'b1;
            r_done_id    <= r_grant_id;
            r_done_resp  <= bus.mon_bresp;
            if (bus.mon_bresp != 2'b00 && r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.m_tvalid   = r_m_tvalid;
  assign bus.m_taddr    = r_m_taddr;
  assign bus.m_tdata    = r_m_tdata;
  assign bus.done_valid = r_done_valid;
  assign bus.done_id    = r_done_id;
  assign bus.done_resp  = r_done_resp;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err_cnt    = r_err_cnt;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Directed bench for axi_lite_write_arbiter: arbitration order, backpressure,
// error counting, spurious B snoops and reset while a write is in flight.
module tb_axi_lite_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_WD = 8;
  localparam int DATA_WD = 8;
  localparam int ID_WD   = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT_B = 2'd2;

  logic clk;
  logic rst;

  axi_lite_write_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD)
  ) bus ();

  axi_lite_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  int outstanding = 0;
  logic [ID_WD-1:0] exp_q[$];
  logic [ADDR_WD-1:0] addr_tab [NUM_REQ];
  logic [DATA_WD-1:0] data_tab [NUM_REQ];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // At most one accepted write may be outstanding until its completion pulse.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (bus.done_valid) outstanding = 0;
      if (|(bus.req_valid & bus.req_ready)) begin
        check_eq("one_inflight", 32'(outstanding), 32'd0);
        outstanding = 1;
      end
    end
  end

  // One full write: wait for grant, optional stall, optional spurious B in ISSUE, B fire.
  task automatic run_txn(input int id, input int stall, input logic [1:0] bresp, input bit spur);
    int n;
    logic [ID_WD-1:0] eid;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("grant_seen", 32'(bus.req_ready != '0), 32'd1);
    if (bus.req_ready == '0) return;
    check_eq("req_ready_onehot", 32'(bus.req_ready), 32'(1) << id);
    check_eq("tvalid_before", 32'(bus.m_tvalid), 32'd0);
    exp_q.push_back(ID_WD'(id));

    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.m_tready  = (stall == 0);
    if (spur) begin
      bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1; bus.mon_bresp = 2'b10;
    end
    #1;
    check_eq("tvalid_rise", 32'(bus.m_tvalid), 32'd1);
    check_eq("taddr", 32'(bus.m_taddr), 32'(addr_tab[id]));
    check_eq("tdata", 32'(bus.m_tdata), 32'(data_tab[id]));
    check_eq("state_issue", 32'(bus.state), 32'(S_ISSUE));
    check_eq("busy_issue", 32'(bus.busy), 32'd1);

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
      if (s == stall - 1) bus.m_tready = 1'b1;
      #1;
      check_eq("stall_tvalid", 32'(bus.m_tvalid), 32'd1);
      check_eq("stall_taddr", 32'(bus.m_taddr), 32'(addr_tab[id]));
      check_eq("stall_tdata", 32'(bus.m_tdata), 32'(data_tab[id]));
      check_eq("stall_ready0", 32'(bus.req_ready), 32'd0);
      check_eq("stall_busy", 32'(bus.busy), 32'd1);
      check_eq("stall_no_done", 32'(bus.done_valid), 32'd0);
      check_eq("stall_err", 32'(bus.err_cnt), 32'(exp_err));
    end

    @(posedge clk); #1;
    bus.m_tready = 1'b0;
    bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
    #1;
    check_eq("state_wait_b", 32'(bus.state), 32'(S_WAIT_B));
    check_eq("tvalid_clear", 32'(bus.m_tvalid), 32'd0);
    check_eq("no_early_done", 32'(bus.done_valid), 32'd0);
    check_eq("err_before_b", 32'(bus.err_cnt), 32'(exp_err));

    bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1; bus.mon_bresp = bresp;
    @(posedge clk); #1;
    bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
    if (bresp != 2'b00 && exp_err < 255) exp_err++;
    #1;
    eid = exp_q.pop_front();
    check_eq("done_valid", 32'(bus.done_valid), 32'd1);
    check_eq("done_id", 32'(bus.done_id), 32'(eid));
    check_eq("done_resp", 32'(bus.done_resp), 32'(bresp));
    check_eq("err_cnt", 32'(bus.err_cnt), 32'(exp_err));
    check_eq("idle_after_b", 32'(bus.busy), 32'd0);

    @(posedge clk); #2;
    check_eq("done_one_cycle", 32'(bus.done_valid), 32'd0);
    check_eq("done_id_hold", 32'(bus.done_id), 32'(eid));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_tab[i] = (i == 2) ? 8'h10 : 8'(8'h40 + i);
      data_tab[i] = (i == 2) ? 8'hA5 : 8'(8'hC0 + i);
    end
    rst = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_WD +: ADDR_WD] = addr_tab[i];
      bus.req_data[i*DATA_WD +: DATA_WD] = data_tab[i];
    end
    bus.m_tready = 1'b0;
    bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0; bus.mon_bresp = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(bus.state), 32'(S_IDLE));
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    check_eq("rst_taddr", 32'(bus.m_taddr), 32'd0);
    check_eq("rst_tdata", 32'(bus.m_tdata), 32'd0);
    check_eq("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check_eq("rst_done_id", 32'(bus.done_id), 32'd0);
    check_eq("rst_done_resp", 32'(bus.done_resp), 32'd0);
    check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fairness: all requesters valid, order 0,1,2,3,0,1,2,3
    for (int t = 0; t < 8; t++) begin
      bus.req_valid = 4'hF;
      run_txn(t % 4, 0, 2'b00, 1'b0);
    end

    // Single write from requester 2
    bus.req_valid = 4'b0100;
    run_txn(2, 0, 2'b00, 1'b0);

    // Backpressure for 5 cycles
    bus.req_valid = 4'b0010;
    run_txn(1, 5, 2'b00, 1'b0);

    // SLVERR with a spurious B during ISSUE
    bus.req_valid = 4'b1000;
    run_txn(3, 2, 2'b10, 1'b1);

    // Spurious B in IDLE
    @(posedge clk); #1;
    bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1; bus.mon_bresp = 2'b11;
    @(posedge clk); #1;
    bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
    #1;
    check_eq("spur_idle_done", 32'(bus.done_valid), 32'd0);
    check_eq("spur_idle_err", 32'(bus.err_cnt), 32'd1);
    check_eq("spur_idle_state", 32'(bus.state), 32'(S_IDLE));

    // Reset while in WAIT_B
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.m_tready = 1'b1;
    @(posedge clk); #1;
    bus.m_tready = 1'b0;
    #1;
    check_eq("pre_rst_wait_b", 32'(bus.state), 32'(S_WAIT_B));
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_state", 32'(bus.state), 32'(S_IDLE));
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_tvalid", 32'(bus.m_tvalid), 32'd0);
    check_eq("arst_taddr", 32'(bus.m_taddr), 32'd0);
    check_eq("arst_done_id", 32'(bus.done_id), 32'd0);
    check_eq("arst_done_resp", 32'(bus.done_resp), 32'd0);
    check_eq("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
    bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1; bus.mon_bresp = 2'b00;
    @(posedge clk); #1;
    bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
    rst = 1'b0;
    exp_err = 0;
    exp_q.delete();
    @(posedge clk); #2;
    check_eq("post_rst_no_done", 32'(bus.done_valid), 32'd0);
    check_eq("post_rst_idle", 32'(bus.state), 32'(S_IDLE));

    // After reset requester 1 wins over 3
    bus.req_valid = 4'b1010;
    run_txn(1, 0, 2'b00, 1'b0);

    // 300 SLVERR writes saturate err_cnt
    for (int t = 0; t < 300; t++) begin
      bus.req_valid = 4'b0001;
      run_txn(0, 0, 2'b10, 1'b0);
    end
    check_eq("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
